mips_multicycle_ctrl: RTL and testbench

Multicycle control FSM for the MIPS datapath: the initiator side of the ALU interface. It sequences fetch/decode/execute/memory/write-back, drives `aluop` and the operand selects into the ALU, and consumes the ALU `zero` flag to resolve branches. It also drives the memory and register-file enables and a single-cycle retire pulse, and waits on a memory-ready handshake.

---
 rtl/mips_ctrl_pkg.sv | 46 ++++
 rtl/alu_op_decoder.sv | 42 ++++
 rtl/mips_multicycle_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, ALU operations,
// opcode/func values and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
  } state_e;

  // How the ALU operation is chosen in a given state.
  typedef enum logic [2:0] {
    CLS_NONE, CLS_ADD, CLS_SUB, CLS_FUNCT, CLS_IMM
  } alu_cls_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_op_decoder.sv
// Maps the current state class, latched opcode and func field to the ALU
// operation; flags R-type func values the datapath does not support.
module alu_op_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [2:0] cls,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output logic [2:0] aluop,
  output logic       func_illegal
);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    aluop        = ALU_AND;
    func_illegal = 1'b0;
    case (cls)
      CLS_ADD: aluop = ALU_ADD;
      CLS_SUB: aluop = ALU_SUB;
      CLS_FUNCT: begin
        case (func)
          FN_ADD:  aluop = ALU_ADD;
          FN_SUB:  aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_SLT:  aluop = ALU_SLT;
          default: func_illegal = 1'b1;
        endcase
      end
      CLS_IMM: begin
        case (opcode)
          OP_SLTI: aluop = ALU_SLT;
          OP_ANDI: aluop = ALU_AND;
          default: aluop = ALU_ADD;
        endcase
      end
      default: aluop = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// and drives the ALU, memory and register-file controls.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] aluop,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       retire,
  output logic       illegal
);

  state_e     state, state_n;
  logic [5:0] op_q;
  logic [2:0] cls;
  logic [2:0] dec_aluop;
  logic       func_illegal;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      op_q  <= OP_RTYPE;
    end else begin
      state <= state_n;
      if (state == S_DECODE) op_q <= opcode;
    end
  end

  // Class depends on state alone, keeping the decoder out of any loop through
  // the next-state logic that consumes func_illegal.
  always_comb begin
    case (state)
      S_FETCH, S_DECODE, S_MEM_ADDR: cls = CLS_ADD;
      S_BRANCH:                      cls = CLS_SUB;
      S_R_EXEC:                      cls = CLS_FUNCT;
      S_I_EXEC:                      cls = CLS_IMM;
      default:                       cls = CLS_NONE;
    endcase
  end

  alu_op_decoder u_alu_op_decoder (
    .cls          (cls),
    .opcode       (op_q),
    .func         (func),
    .aluop        (dec_aluop),
    .func_illegal (func_illegal)
  );

  // Holding reset low forces every strobe off, even though state reads FETCH.
  assign aluop = rst_n ? dec_aluop : ALU_AND;

  always_comb begin
    state_n    = state;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    ext_zero   = 1'b0;
    pc_src     = PC_ALU;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
          if (mem_ready) state_n = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = SRCB_BRANCH;
          case (opcode)
            OP_LW, OP_SW:              state_n = S_MEM_ADDR;
            OP_RTYPE:                  state_n = S_R_EXEC;
            OP_ADDI, OP_SLTI, OP_ANDI: state_n = S_I_EXEC;
            OP_BEQ, OP_BNE:            state_n = S_BRANCH;
            OP_J:                      state_n = S_JUMP;
            default: begin
              illegal = 1'b1;
              state_n = S_FETCH;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          state_n   = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          if (mem_ready) state_n = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          state_n    = S_FETCH;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          retire    = mem_ready;
          if (mem_ready) state_n = S_FETCH;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          illegal   = func_illegal;
          state_n   = func_illegal ? S_FETCH : S_R_WB;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
          state_n   = S_FETCH;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          ext_zero  = (op_q == OP_ANDI);
          state_n   = S_I_WB;
        end
        S_I_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_n   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          pc_src    = PC_ALUOUT;
          pc_en     = (op_q == OP_BEQ) ? zero : ~zero;
          retire    = 1'b1;
          state_n   = S_FETCH;
        end
        S_JUMP: begin
          pc_src  = PC_JUMP;
          pc_en   = 1'b1;
          retire  = 1'b1;
          state_n = S_FETCH;
        end
        default: state_n = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: an instruction-level model
// predicts every output per cycle, plus literal latency and spot expectations.
module tb_mips_multicycle_ctrl;

  typedef enum int {P_F, P_D, P_MA, P_MR, P_MW, P_SW, P_RE, P_RW, P_IE, P_IW, P_BR, P_J} ph_e;

  typedef struct packed {
    logic [2:0] aluop;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       retire;
    logic       illegal;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n, zero, mem_ready;
  logic [5:0] opcode, func;
  logic [2:0] aluop;
  logic       alu_src_a, ext_zero, pc_en, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, retire, illegal;
  logic [1:0] alu_src_b, pc_src;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .aluop(aluop), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .ext_zero(ext_zero), .pc_src(pc_src), .pc_en(pc_en),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  outs_t dut_o;
  assign dut_o = {aluop, alu_src_a, alu_src_b, ext_zero, pc_src, pc_en, iord, mem_read,
                  mem_write, ir_write, reg_dst, mem_to_reg, reg_write, retire, illegal};

  int         tests = 0, fails = 0;
  int         cyc = 0, retire_cnt = 0, retire_cyc = 0;
  bit         exp_valid = 0;
  outs_t      exp_o;
  outs_t      trace [0:1023];
  ph_e        cur_ph = P_F;
  logic [5:0] cur_op = 6'b0, cur_fn = 6'b0;
  logic       cur_z = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic bit legal_fn(input logic [5:0] fn);
    return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  endfunction

  // Expected outputs for one cycle of an instruction, straight from the
  // per-step control table of the multicycle datapath.
  function automatic outs_t model(input ph_e ph, input logic [5:0] op, input logic [5:0] fn,
                                  input logic z, input logic mr);
    outs_t o = '0;
    case (ph)
      P_F:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.aluop = 3'b010; o.ir_write = mr; o.pc_en = mr; end
      P_D:  begin
        o.alu_src_b = 2'b11; o.aluop = 3'b010;
        o.illegal = !(op inside {6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b001010,
                                 6'b001100, 6'b000100, 6'b000101, 6'b000010});
      end
      P_MA: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.aluop = 3'b010; end
      P_MR: begin o.mem_read = 1; o.iord = 1; end
      P_MW: begin o.reg_write = 1; o.mem_to_reg = 1; o.retire = 1; end
      P_SW: begin o.mem_write = 1; o.iord = 1; o.retire = mr; end
      P_RE: begin
        o.alu_src_a = 1;
        case (fn)
          6'b100000: o.aluop = 3'b010;
          6'b100010: o.aluop = 3'b011;
          6'b100100: o.aluop = 3'b000;
          6'b100101: o.aluop = 3'b001;
          6'b101010: o.aluop = 3'b111;
          default:   o.illegal = 1;
        endcase
      end
      P_RW: begin o.reg_write = 1; o.reg_dst = 1; o.retire = 1; end
      P_IE: begin
        o.alu_src_a = 1; o.alu_src_b = 2'b10;
        o.aluop    = (op == 6'b001010) ? 3'b111 : (op == 6'b001100) ? 3'b000 : 3'b010;
        o.ext_zero = (op == 6'b001100);
      end
      P_IW: begin o.reg_write = 1; o.retire = 1; end
      P_BR: begin
        o.alu_src_a = 1; o.aluop = 3'b011; o.pc_src = 2'b01; o.retire = 1;
        o.pc_en = (op == 6'b000100) ? z : !z;
      end
      P_J:  begin o.pc_src = 2'b10; o.pc_en = 1; o.retire = 1; end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Single compare process: checks every driven cycle and logs what it saw.
  always @(negedge clk) begin
    if (exp_valid && rst_n) begin
      outs_t act, e;
      act = dut_o;
      e   = exp_o;
      if (cur_ph == P_RE && !legal_fn(cur_fn)) begin
        act.aluop = '0;
        e.aluop   = '0;
      end
      check($sformatf("outs cyc%0d ph%0d", cyc, cur_ph), 32'(act), 32'(e));
      trace[cyc] = dut_o;
      if (dut_o.retire) begin
        retire_cnt++;
        retire_cyc = cyc;
      end
    end
  end

  task automatic drive(input ph_e ph, input logic mr);
    cur_ph    = ph;
    mem_ready = mr;
    zero      = cur_z;
    func      = cur_fn;
    // After DECODE the port carries garbage; the DUT must use its latched copy.
    opcode    = (ph == P_F || ph == P_D) ? cur_op : ~cur_op;
    exp_o     = model(ph, cur_op, cur_fn, cur_z, mr);
    cyc++;
    exp_valid = 1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fwait, input int mwait, input int exp_lat,
                           input bit abort, output int c0);
    int r0;
    r0 = retire_cnt;
    c0 = cyc + 1;
    cur_op = op; cur_fn = fn; cur_z = z;
    repeat (fwait) begin drive(P_F, 0); adv(); end
    drive(P_F, 1); adv();
    drive(P_D, 1); adv();
    case (op)
      6'b100011: begin
        drive(P_MA, 1); adv();
        repeat (mwait) begin drive(P_MR, 0); adv(); end
        drive(P_MR, 1); adv();
        drive(P_MW, 1); adv();
      end
      6'b101011: begin
        drive(P_MA, 1); adv();
        repeat (mwait) begin drive(P_SW, 0); adv(); end
        if (abort) begin
          drive(P_SW, 0);
          #1;
          check("sw_wait_mem_write", 32'(mem_write), 32'd1);
          exp_valid = 0;
          rst_n = 1'b0;
          #1;
          check("abort_mem_write", 32'(mem_write), 32'd0);
          check("abort_outs", 32'(dut_o), 32'd0);
          @(posedge clk);
          #1;
          rst_n = 1'b1;
        end else begin
          drive(P_SW, 1); adv();
        end
      end
      6'b000000: begin
        drive(P_RE, 1); adv();
        if (legal_fn(fn)) begin drive(P_RW, 1); adv(); end
      end
      6'b001000, 6'b001010, 6'b001100: begin
        drive(P_IE, 1); adv();
        drive(P_IW, 1); adv();
      end
      6'b000100, 6'b000101: begin drive(P_BR, 1); adv(); end
      6'b000010:            begin drive(P_J, 1); adv(); end
      default: ;
    endcase
    check($sformatf("retire_count op%b", op), retire_cnt - r0, (exp_lat > 0) ? 1 : 0);
    if (exp_lat > 0)
      check($sformatf("latency op%b", op), retire_cyc - c0 + 1, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [5:0] rfns [4];
    rfns = '{6'b100000, 6'b100100, 6'b100101, 6'b101010};
    rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; opcode = 6'b0; func = 6'b0;

    #3 check("reset_outs_early", 32'(dut_o), 32'd0);
    @(posedge clk); #1;
    check("reset_outs_edge", 32'(dut_o), 32'd0);
    rst_n = 1'b1;

    // R-type SUB straight out of reset.
    run_instr(6'b000000, 6'b100010, 0, 0, 0, 4, 0, c);
    check("first_fetch_strobes", {29'd0, trace[c].mem_read, trace[c].ir_write, trace[c].pc_en}, 32'b111);
    check("first_fetch_aluop", 32'(trace[c].aluop), 32'b010);
    check("rsub_exec_aluop", 32'(trace[c+2].aluop), 32'b011);
    check("rsub_wb", {29'd0, trace[c+3].reg_write, trace[c+3].reg_dst, trace[c+3].retire}, 32'b111);

    foreach (rfns[i]) run_instr(6'b000000, rfns[i], 0, 0, 0, 4, 0, c);

    // lw with two wait cycles in MEM_RD.
    run_instr(6'b100011, 6'b0, 0, 0, 2, 7, 0, c);
    for (int k = 3; k <= 5; k++)
      check($sformatf("lw_wait_strobes k%0d", k), {30'd0, trace[c+k].mem_read, trace[c+k].iord}, 32'b11);
    check("lw_wb", {30'd0, trace[c+6].mem_to_reg, trace[c+6].retire}, 32'b11);

    run_instr(6'b100011, 6'b0, 0, 0, 0, 5, 0, c);
    run_instr(6'b101011, 6'b0, 0, 0, 0, 4, 0, c);
    run_instr(6'b101011, 6'b0, 0, 1, 1, 6, 0, c);
    run_instr(6'b001000, 6'b0, 0, 0, 0, 4, 0, c);
    run_instr(6'b001010, 6'b0, 0, 0, 0, 4, 0, c);
    check("slti_aluop", 32'(trace[c+2].aluop), 32'b111);
    run_instr(6'b001100, 6'b0, 0, 0, 0, 4, 0, c);
    check("andi_ext_zero", {29'd0, trace[c+2].aluop}, 32'b000);
    check("andi_ext_flag", 32'(trace[c+2].ext_zero), 32'd1);

    run_instr(6'b000100, 6'b0, 1, 0, 0, 3, 0, c);
    check("beq_taken", {29'd0, trace[c+2].pc_en, trace[c+2].pc_src}, 32'b101);
    run_instr(6'b000101, 6'b0, 1, 0, 0, 3, 0, c);
    check("bne_not_taken", 32'(trace[c+2].pc_en), 32'd0);
    run_instr(6'b000100, 6'b0, 0, 0, 0, 3, 0, c);
    run_instr(6'b000101, 6'b0, 0, 0, 0, 3, 0, c);
    run_instr(6'b000010, 6'b0, 0, 0, 0, 3, 0, c);

    // Illegal opcode, then prove the FSM is back in FETCH.
    run_instr(6'b111111, 6'b0, 0, 0, 0, 0, 0, c);
    check("illegal_op_pulse", 32'(trace[c+1].illegal), 32'd1);
    run_instr(6'b001000, 6'b0, 0, 0, 0, 4, 0, c);

    // Unsupported R-type func: no write-back at any point.
    run_instr(6'b000000, 6'b000111, 0, 0, 0, 0, 0, c);
    check("illegal_fn_pulse", 32'(trace[c+2].illegal), 32'd1);
    for (int k = 0; k <= 2; k++)
      check($sformatf("illegal_fn_no_write k%0d", k), 32'(trace[c+k].reg_write), 32'd0);

    // Reset during a store wait aborts without retire; next instruction starts clean.
    run_instr(6'b101011, 6'b0, 0, 0, 1, 0, 1, c);
    run_instr(6'b001000, 6'b0, 0, 0, 0, 4, 0, c);

    exp_valid = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
